// File: rtl/cla_mult_seq.sv
// Shift-and-add multiplier sequencer that drives one shared, purely combinational CLA.
// Define EARLY_TERM_EN to end RUN as soon as the remaining multiplier bits are all zero.
module cla_mult_seq #(
    parameter int N_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  signed_op,
    input  logic [N_BITS-1:0]     mcand,
    input  logic [N_BITS-1:0]     mplier,
    output logic [2*N_BITS-1:0]   cla_A,
    output logic [2*N_BITS-1:0]   cla_B,
    output logic                  cla_sub,
    input  logic [2*N_BITS-1:0]   cla_Sum,
    output logic                  busy,
    output logic                  done,
    output logic [2*N_BITS-1:0]   product
);

    localparam int PW = 2 * N_BITS;
    localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(N_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     acc_next;
    logic [PW-1:0]     mc_sh;
    logic [PW-1:0]     mc_ext;
    logic [N_BITS-1:0] mp_sh;
    logic [N_BITS-1:0] mp_next;
    logic [CW-1:0]     count;
    logic              signed_q;
    logic              last_step;

    assign mc_ext   = signed_op ? {{N_BITS{mcand[N_BITS-1]}}, mcand}
                                : {{N_BITS{1'b0}}, mcand};
    assign mp_next  = mp_sh >> 1;
    assign acc_next = mp_sh[0] ? cla_Sum : acc;

    // A signed negative multiplier keeps its MSB set, so early exit never skips the subtract step.
`ifdef EARLY_TERM_EN
    assign last_step = (count == LAST_STEP) || (mp_next == '0);
`else
    assign last_step = (count == LAST_STEP);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // CLA inputs are forced to zero outside RUN so the shared adder sees a quiet input.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        cla_A   = '0;
        cla_B   = '0;
        cla_sub = 1'b0;
        case (state)
            RUN: begin
                busy    = 1'b1;
                cla_A   = acc;
                cla_B   = mc_sh;
                cla_sub = signed_q && (count == LAST_STEP) && mp_sh[0];
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc      <= '0;
            mc_sh    <= '0;
            mp_sh    <= '0;
            count    <= '0;
            signed_q <= 1'b0;
            product  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        mc_sh    <= mc_ext;
                        mp_sh    <= mplier;
                        count    <= '0;
                        signed_q <= signed_op;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    mc_sh <= mc_sh << 1;
                    mp_sh <= mp_next;
                    count <= count + 1'b1;
                    // Capture the final accumulator on the edge that enters DONE.
                    if (last_step) begin
                        product <= acc_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_mult_seq.sv
// Self-checking bench for cla_mult_seq: models the external CLA, predicts every output
// each cycle from plain multiplication arithmetic, and pins the model with literal products.
module tb_cla_mult_seq;

    localparam int N  = 8;
    localparam int PW = 16;
`ifdef EARLY_TERM_EN
    localparam int SHORT_LAT = 2;
`else
    localparam int SHORT_LAT = 9;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          signed_op = 1'b0;
    logic [N-1:0]  mcand = '0;
    logic [N-1:0]  mplier = '0;
    logic [PW-1:0] cla_A;
    logic [PW-1:0] cla_B;
    logic          cla_sub;
    logic [PW-1:0] cla_Sum;
    logic          busy;
    logic          done;
    logic [PW-1:0] product;

    int n_checks = 0;
    int n_pass   = 0;

    int            m_left   = 0;
    int            m_runlen = 0;
    logic [N-1:0]  m_a      = '0;
    logic [N-1:0]  m_b      = '0;
    logic          m_signed = 1'b0;
    logic [PW-1:0] m_prod   = '0;
    int            done_seen = 0;
    int            sub_seen  = 0;

    cla_mult_seq #(.N_BITS(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .signed_op(signed_op),
        .mcand    (mcand),
        .mplier   (mplier),
        .cla_A    (cla_A),
        .cla_B    (cla_B),
        .cla_sub  (cla_sub),
        .cla_Sum  (cla_Sum),
        .busy     (busy),
        .done     (done),
        .product  (product)
    );

    assign cla_Sum = cla_sub ? (cla_A - cla_B) : (cla_A + cla_B);

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int run_len(input logic [N-1:0] b);
        int hi;
        hi = 0;
        for (int i = 0; i < N; i++) begin
            if (b[i]) hi = i + 1;
        end
`ifdef EARLY_TERM_EN
        return (hi == 0) ? 1 : hi;
`else
        return (hi >= 0) ? N : N;
`endif
    endfunction

    function automatic logic [PW-1:0] ext(input logic [N-1:0] v, input logic s);
        return s ? {{N{v[N-1]}}, v} : {{N{1'b0}}, v};
    endfunction

    function automatic logic [PW-1:0] full_product(input logic [N-1:0] a, input logic [N-1:0] b,
                                                   input logic s);
        int x;
        int y;
        x = s ? int'($signed(a)) : int'(a);
        y = s ? int'($signed(b)) : int'(b);
        return PW'(x * y);
    endfunction

    // Protocol model: busy for run_len+1 cycles after an accepted start, done in the last one.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_prod = '0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 1) m_prod = full_product(m_a, m_b, m_signed);
        end else if (start) begin
            m_a      = mcand;
            m_b      = mplier;
            m_signed = signed_op;
            m_runlen = run_len(mplier);
            m_left   = m_runlen + 1;
        end
    end

    // In step k the accumulator holds mc times the k low multiplier bits, and B is mc<<k.
    always @(negedge clk) begin : compare
        int            k;
        int            mlow;
        logic [PW-1:0] exp_a;
        logic [PW-1:0] exp_b;
        logic          exp_sub;
        exp_a   = '0;
        exp_b   = '0;
        exp_sub = 1'b0;
        if (m_left > 1) begin
            k       = m_runlen + 1 - m_left;
            mlow    = int'(m_b) & ((1 << k) - 1);
            exp_a   = PW'(int'(ext(m_a, m_signed)) * mlow);
            exp_b   = PW'(int'(ext(m_a, m_signed)) << k);
            exp_sub = m_signed && (k == N - 1) && m_b[k];
        end
        checkOutput("busy",    32'(busy),    32'(m_left > 0));
        checkOutput("done",    32'(done),    32'(m_left == 1));
        checkOutput("product", 32'(product), 32'(m_prod));
        checkOutput("cla_A",   32'(cla_A),   32'(exp_a));
        checkOutput("cla_B",   32'(cla_B),   32'(exp_b));
        checkOutput("cla_sub", 32'(cla_sub), 32'(exp_sub));
        if (done) done_seen++;
        if (cla_sub) sub_seen++;
    end

    task automatic applyStimulus(input logic s, input logic [N-1:0] a, input logic [N-1:0] b,
                                 input bit hold, output int lat);
        bit found;
        found = 0;
        lat   = 0;
        @(negedge clk);
        #2;
        start     = 1'b1;
        signed_op = s;
        mcand     = a;
        mplier    = b;
        for (int i = 1; i <= 40 && !found; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1;
                lat   = i;
            end
            #2;
            if (hold && !found) begin
                mcand     = N'($urandom);
                mplier    = N'($urandom);
                signed_op = 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        if (!found) checkOutput("done_timeout", 32'(0), 32'(1));
    endtask

    initial begin
        int           lat;
        logic         s;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] edge_vals [5];
        edge_vals = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};

        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy",    32'(busy),    32'(0));
        checkOutput("reset_done",    32'(done),    32'(0));
        checkOutput("reset_product", 32'(product), 32'(0));
        checkOutput("reset_cla_A",   32'(cla_A),   32'(0));
        #2 rst = 1'b0;

        applyStimulus(1'b0, 8'hFF, 8'hFF, 0, lat);
        checkOutput("u_ff_ff", 32'(product), 32'h0000FE01);
        checkOutput("u_ff_ff_lat", 32'(lat), 32'(9));

        sub_seen = 0;
        applyStimulus(1'b1, 8'hFF, 8'h02, 0, lat);
        checkOutput("s_m1_x_2", 32'(product), 32'h0000FFFE);
        checkOutput("s_m1_x_2_sub", 32'(sub_seen), 32'(0));

        sub_seen = 0;
        applyStimulus(1'b1, 8'h02, 8'hFF, 0, lat);
        checkOutput("s_2_x_m1", 32'(product), 32'h0000FFFE);
        checkOutput("s_2_x_m1_lat", 32'(lat), 32'(9));
        checkOutput("s_2_x_m1_sub", 32'(sub_seen), 32'(1));

        applyStimulus(1'b1, 8'h80, 8'h80, 0, lat);
        checkOutput("s_80_80", 32'(product), 32'h00004000);
        applyStimulus(1'b1, 8'h7F, 8'h80, 0, lat);
        checkOutput("s_7f_80", 32'(product), 32'h0000C080);

        applyStimulus(1'b0, 8'h03, 8'h01, 0, lat);
        checkOutput("u_03_01", 32'(product), 32'h00000003);
        checkOutput("u_03_01_lat", 32'(lat), 32'(SHORT_LAT));
        applyStimulus(1'b0, 8'h55, 8'h00, 0, lat);
        checkOutput("u_55_00", 32'(product), 32'h00000000);
        checkOutput("u_55_00_lat", 32'(lat), 32'(SHORT_LAT));

        // start stays high through the whole operation while operands keep changing.
        done_seen = 0;
        applyStimulus(1'b0, 8'h12, 8'h34, 1, lat);
        checkOutput("hold_lat", 32'(lat), 32'(run_len(8'h34) + 1));
        repeat (3) @(negedge clk);
        checkOutput("hold_product", 32'(product), 32'h000003A8);
        checkOutput("hold_single_done", 32'(done_seen), 32'(1));

        // Reset during RUN cycle 4 aborts the operation.
        done_seen = 0;
        @(negedge clk);
        #2;
        start = 1'b1; signed_op = 1'b0; mcand = 8'hFF; mplier = 8'hFF;
        @(negedge clk);
        #2 start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (12) @(negedge clk);
        checkOutput("abort_done", 32'(done_seen), 32'(0));
        checkOutput("abort_busy", 32'(busy), 32'(0));
        checkOutput("abort_product", 32'(product), 32'(0));

        for (int n = 0; n < 500; n++) begin
            s = 1'($urandom);
            a = ($urandom_range(0, 7) == 0) ? edge_vals[$urandom_range(0, 4)] : N'($urandom);
            b = ($urandom_range(0, 7) == 0) ? edge_vals[$urandom_range(0, 4)] : N'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            applyStimulus(s, a, b, 0, lat);
            checkOutput("rand_product", 32'(product), 32'(full_product(a, b, s)));
            checkOutput("rand_lat", 32'(lat), 32'(run_len(b) + 1));
        end

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
